demod_dac_conditioner: RTL

Parametrised output conditioner between the demodulator cores (AM AC/DC, FIR, future FM) and the AD9764 DAC driver. It selects one of NUM_CH signed demod channels and optionally removes DC using a block-averaged estimator. It then applies a programmable power-of-two gain and offset, and saturates to an unsigned OUT_W DAC code. Replaces the fixed offset/shift/clamp arithmetic in the top level and adds clip monitoring.

---
 rtl/demod_dac_conditioner_pkg.sv | 21 ++
 rtl/demod_dac_conditioner_if.sv | 14 +
 rtl/demod_dac_conditioner_dc_block_avg.sv | 61 ++++++
 rtl/demod_dac_conditioner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/demod_dac_conditioner_pkg.sv
// Shared types and constants for the demod-to-DAC output conditioner.
// Mode encodings, the DAC midscale code and the channel-select width helper.
package demod_dac_conditioner_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_DCRM = 2'd1,
    MODE_DC   = 2'd2,
    MODE_MUTE = 2'd3
  } mode_e;

  function automatic logic [31:0] midscale(input int out_w);
    return 32'd1 << (out_w - 1);
  endfunction

  // A single-channel build still carries a one-bit select
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/demod_dac_conditioner_if.sv
// Sample stream into the conditioner and DAC code stream out of it.
interface demod_dac_conditioner_if #(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 14,
  parameter int NUM_CH = 2
);
  logic [NUM_CH*IN_W-1:0] in_data;
  logic                   in_valid;
  logic [OUT_W-1:0]       out_data;
  logic                   out_valid;

  modport master (output in_data, output in_valid, input out_data, input out_valid);
  modport slave  (input in_data, input in_valid, output out_data, output out_valid);
endinterface

// File: rtl/demod_dac_conditioner_dc_block_avg.sv
// Block-averaged DC estimator: mean of 2^AVG_LOG2 consecutive same-channel samples.
// A channel change restarts the block without disturbing the published estimate.
module demod_dac_conditioner_dc_block_avg #(
  parameter int IN_W     = 12,
  parameter int AVG_LOG2 = 10,
  parameter int CH_W     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  input  logic signed [IN_W-1:0] sample,
  input  logic [CH_W-1:0]        ch,
  output logic signed [IN_W-1:0] dc_est,
  output logic                   dc_valid
);
  localparam int ACC_W = IN_W + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic [AVG_LOG2-1:0]     cnt_reg;
  logic [CH_W-1:0]         last_ch_reg;
  logic signed [IN_W-1:0]  dc_est_reg;
  logic                    dc_valid_reg;
  logic                    restart;
  logic                    wrap;

  assign sample_ext = {{AVG_LOG2{sample[IN_W-1]}}, sample};
  assign acc_next   = acc_reg + sample_ext;
  assign restart    = (ch != last_ch_reg);
  assign wrap       = (cnt_reg == '1) && !restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      last_ch_reg  <= '0;
      dc_est_reg   <= '0;
      dc_valid_reg <= 1'b0;
    end else if (sample_valid) begin
      last_ch_reg <= ch;
      if (restart) begin
        acc_reg <= sample_ext;
        cnt_reg <= AVG_LOG2'(1);
      end else if (wrap) begin
        // Upper slice of the full sum is the arithmetic shift, floor rounding
        acc_reg      <= '0;
        cnt_reg      <= '0;
        dc_est_reg   <= acc_next[ACC_W-1:AVG_LOG2];
        dc_valid_reg <= 1'b1;
      end else begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + AVG_LOG2'(1);
      end
    end
  end

  assign dc_est   = dc_est_reg;
  assign dc_valid = dc_valid_reg;

endmodule

// File: rtl/demod_dac_conditioner.sv
// Channel select, optional DC removal, power-of-two gain, offset and saturation
// to an unsigned DAC code, with a saturating clip counter. Four-stage pipeline.
module demod_dac_conditioner
  import demod_dac_conditioner_pkg::*;
#(
  parameter int IN_W     = 12,
  parameter int OUT_W    = 14,
  parameter int NUM_CH   = 2,
  parameter int AVG_LOG2 = 10,
  parameter int CNT_W    = 16,
  localparam int CH_W    = sel_width(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demod_dac_conditioner_if.slave bus,
  input  logic [CH_W-1:0]        ch_sel,
  input  logic [1:0]             mode,
  input  logic [3:0]             gain_shift,
  input  logic signed [OUT_W:0]  offset,
  input  logic                   clr_clip,
  output logic signed [IN_W-1:0] dc_est,
  output logic                   dc_valid,
  output logic [CNT_W-1:0]       clip_cnt
);
  localparam int IW = OUT_W + IN_W + 17;
  localparam logic [OUT_W-1:0] CODE_MAX = '1;
  localparam logic [OUT_W-1:0] CODE_MID = OUT_W'(midscale(OUT_W));

  logic signed [IN_W-1:0] ch_sample [NUM_CH];
  logic [CH_W-1:0]        ch_eff;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_sample[gi] = bus.in_data[gi*IN_W +: IN_W];
    end
  endgenerate

  assign ch_eff = (int'(ch_sel) >= NUM_CH) ? '0 : ch_sel;

  // S1: sample and its control settings travel together down the pipe
  logic signed [IN_W-1:0] s1_x_reg;
  logic [CH_W-1:0]        s1_ch_reg;
  mode_e                  s1_mode_reg;
  logic [3:0]             s1_gain_reg;
  logic signed [OUT_W:0]  s1_offset_reg;
  logic                   s1_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_x_reg      <= '0;
      s1_ch_reg     <= '0;
      s1_mode_reg   <= MODE_PASS;
      s1_gain_reg   <= '0;
      s1_offset_reg <= '0;
    end else begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_x_reg      <= ch_sample[ch_eff];
        s1_ch_reg     <= ch_eff;
        s1_mode_reg   <= mode_e'(mode);
        s1_gain_reg   <= gain_shift;
        s1_offset_reg <= offset;
      end
    end
  end

  demod_dac_conditioner_dc_block_avg #(
    .IN_W    (IN_W),
    .AVG_LOG2(AVG_LOG2),
    .CH_W    (CH_W)
  ) u_dc_avg (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(s1_valid_reg),
    .sample      (s1_x_reg),
    .ch          (s1_ch_reg),
    .dc_est      (dc_est),
    .dc_valid    (dc_valid)
  );

  // S2: DC stage
  logic signed [IW-1:0]  x_ext;
  logic signed [IW-1:0]  dc_ext;
  logic signed [IW-1:0]  v_next;
  logic signed [IW-1:0]  s2_v_reg;
  logic [3:0]            s2_gain_reg;
  logic signed [OUT_W:0] s2_offset_reg;
  logic                  s2_valid_reg;

  assign x_ext  = {{(IW-IN_W){s1_x_reg[IN_W-1]}}, s1_x_reg};
  assign dc_ext = dc_valid ? {{(IW-IN_W){dc_est[IN_W-1]}}, dc_est} : '0;

  always_comb begin
    v_next = '0;
    case (s1_mode_reg)
      MODE_PASS: v_next = x_ext;
      MODE_DCRM: v_next = x_ext - dc_ext;
      MODE_DC:   v_next = dc_ext;
      MODE_MUTE: v_next = '0;
      default:   v_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg  <= 1'b0;
      s2_v_reg      <= '0;
      s2_gain_reg   <= '0;
      s2_offset_reg <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_v_reg      <= v_next;
        s2_gain_reg   <= s1_gain_reg;
        s2_offset_reg <= s1_offset_reg;
      end
    end
  end

  // S3: gain and offset at full precision; IW leaves headroom for a 15-bit shift
  logic signed [IW-1:0] off_ext;
  logic signed [IW-1:0] w_next;
  logic signed [IW-1:0] s3_w_reg;
  logic                 s3_valid_reg;

  assign off_ext = {{(IW-OUT_W-1){s2_offset_reg[OUT_W]}}, s2_offset_reg};
  assign w_next  = (s2_v_reg <<< s2_gain_reg) + off_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_reg <= 1'b0;
      s3_w_reg     <= '0;
    end else begin
      s3_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) s3_w_reg <= w_next;
    end
  end

  // S4: clamp to the DAC code range and count clipped outputs
  logic [OUT_W-1:0] code_next;
  logic             clip;
  logic [CNT_W-1:0] clip_cnt_next;
  logic [CNT_W-1:0] clip_cnt_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             out_valid_reg;

  always_comb begin
    code_next = s3_w_reg[OUT_W-1:0];
    clip      = 1'b0;
    if (s3_w_reg[IW-1]) begin
      code_next = '0;
      clip      = 1'b1;
    end else if (|s3_w_reg[IW-2:OUT_W]) begin
      code_next = CODE_MAX;
      clip      = 1'b1;
    end
  end

  always_comb begin
    clip_cnt_next = clip_cnt_reg;
    if (clr_clip) clip_cnt_next = '0;
    else if (s3_valid_reg && clip && (clip_cnt_reg != '1)) clip_cnt_next = clip_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= CODE_MID;
      out_valid_reg <= 1'b0;
      clip_cnt_reg  <= '0;
    end else begin
      out_valid_reg <= s3_valid_reg;
      clip_cnt_reg  <= clip_cnt_next;
      if (s3_valid_reg) out_data_reg <= code_next;
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign clip_cnt      = clip_cnt_reg;

endmodule
